axi_sync_framer: RTL and testbench

- Sits directly downstream of the pipelined equality comparator; consumes its data/user stream plus the per-beat equal flag.
- Hunts for SYNC_COUNT consecutive equal (sync-word) beats, drops them, then forwards exactly frame_len payload beats as one framed packet with m_axi_last on the final beat, and returns to hunting.
- Supplies lock and frame/drop counters for status registers.

---
 rtl/axi_sync_framer.sv | 164 ++++++++++++++++
 tb/tb_axi_sync_framer.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_sync_framer.sv
// Sync-word framer: hunts for SYNC_COUNT consecutive equal beats, then forwards
// frame_len payload beats as one packet with m_axi_last on the final beat.
module axi_sync_framer #(
    parameter int DWIDTH     = 64,
    parameter int UWIDTH     = 8,
    parameter int SYNC_COUNT = 2,
    parameter int LWIDTH     = 16
) (
    input  logic              clk,
    input  logic              areset,
    input  logic [LWIDTH-1:0] frame_len,
    output logic              s_axi_ready,
    input  logic              s_axi_valid,
    input  logic [DWIDTH-1:0] s_axi_data,
    input  logic [UWIDTH-1:0] s_axi_user,
    input  logic              s_axi_equal,
    input  logic              m_axi_ready,
    output logic              m_axi_valid,
    output logic [DWIDTH-1:0] m_axi_data,
    output logic [UWIDTH-1:0] m_axi_user,
    output logic              m_axi_last,
    output logic              locked,
    output logic [LWIDTH-1:0] frame_count,
    output logic [15:0]       drop_count
);

    typedef enum logic [0:0] {
        HUNT    = 1'b0,
        PAYLOAD = 1'b1
    } state_t;

    localparam logic [7:0]        SYNC_LAST = 8'(SYNC_COUNT - 1);
    localparam logic [LWIDTH-1:0] LEN_ONE   = {{(LWIDTH-1){1'b0}}, 1'b1};
    localparam logic [LWIDTH-1:0] LEN_ZERO  = {LWIDTH{1'b0}};

    state_t              state_r, state_nxt_s;
    logic [7:0]          sync_cnt_r, sync_cnt_nxt_s;
    logic [LWIDTH-1:0]   beat_cnt_r, beat_cnt_nxt_s;
    logic [LWIDTH-1:0]   len_q_r, len_q_nxt_s;
    logic                m_valid_r, m_last_r, locked_r;
    logic [DWIDTH-1:0]   m_data_r;
    logic [UWIDTH-1:0]   m_user_r;
    logic [LWIDTH-1:0]   frame_count_r;
    logic [15:0]         drop_count_r, drop_nxt_s;
    logic [16:0]         drop_sum_s;
    logic                s_axi_ready_s, accept_s, load_s, last_nxt_s;
    logic                drop_inc_s, frame_inc_s;

    assign s_axi_ready_s = !m_valid_r || m_axi_ready;
    assign accept_s      = s_axi_valid && s_axi_ready_s;

    assign s_axi_ready = s_axi_ready_s;
    assign m_axi_valid = m_valid_r;
    assign m_axi_data  = m_data_r;
    assign m_axi_user  = m_user_r;
    assign m_axi_last  = m_last_r;
    assign locked      = locked_r;
    assign frame_count = frame_count_r;
    assign drop_count  = drop_count_r;

    // A broken sync attempt discards the pending equal beats plus the breaking beat.
    assign drop_sum_s = {1'b0, drop_count_r} + {9'd0, sync_cnt_r} + 17'd1;
    assign drop_nxt_s = drop_sum_s[16] ? 16'hFFFF : drop_sum_s[15:0];

    // Next-state and per-beat control decisions.
    always_comb begin
        state_nxt_s    = state_r;
        sync_cnt_nxt_s = sync_cnt_r;
        beat_cnt_nxt_s = beat_cnt_r;
        len_q_nxt_s    = len_q_r;
        load_s         = 1'b0;
        last_nxt_s     = 1'b0;
        drop_inc_s     = 1'b0;
        frame_inc_s    = 1'b0;
        case (state_r)
            HUNT: begin
                if (accept_s && s_axi_equal && (sync_cnt_r == SYNC_LAST)) begin
                    state_nxt_s    = PAYLOAD;
                    sync_cnt_nxt_s = 8'd0;
                    beat_cnt_nxt_s = LEN_ZERO;
                    len_q_nxt_s    = (frame_len == LEN_ZERO) ? LEN_ONE : frame_len;
                end else if (accept_s && s_axi_equal) begin
                    sync_cnt_nxt_s = sync_cnt_r + 8'd1;
                end else if (accept_s) begin
                    sync_cnt_nxt_s = 8'd0;
                    drop_inc_s     = 1'b1;
                end else begin
                    sync_cnt_nxt_s = sync_cnt_r;
                end
            end
            PAYLOAD: begin
                if (accept_s) begin
                    load_s         = 1'b1;
                    beat_cnt_nxt_s = beat_cnt_r + LEN_ONE;
                    if (beat_cnt_r == (len_q_r - LEN_ONE)) begin
                        last_nxt_s     = 1'b1;
                        frame_inc_s    = 1'b1;
                        state_nxt_s    = HUNT;
                        sync_cnt_nxt_s = 8'd0;
                    end else begin
                        last_nxt_s = 1'b0;
                    end
                end else begin
                    beat_cnt_nxt_s = beat_cnt_r;
                end
            end
            default: begin
                state_nxt_s    = HUNT;
                sync_cnt_nxt_s = 8'd0;
            end
        endcase
    end

    // State, counters and status registers.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_r       <= HUNT;
            sync_cnt_r    <= 8'd0;
            beat_cnt_r    <= LEN_ZERO;
            len_q_r       <= LEN_ONE;
            locked_r      <= 1'b0;
            frame_count_r <= LEN_ZERO;
            drop_count_r  <= 16'd0;
        end else begin
            state_r    <= state_nxt_s;
            sync_cnt_r <= sync_cnt_nxt_s;
            beat_cnt_r <= beat_cnt_nxt_s;
            len_q_r    <= len_q_nxt_s;
            locked_r   <= (state_nxt_s == PAYLOAD);
            if (frame_inc_s) begin
                frame_count_r <= frame_count_r + LEN_ONE;
            end else begin
                frame_count_r <= frame_count_r;
            end
            if (drop_inc_s) begin
                drop_count_r <= drop_nxt_s;
            end else begin
                drop_count_r <= drop_count_r;
            end
        end
    end

    // Single-stage output register; holds its beat while stalled.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            m_valid_r <= 1'b0;
            m_last_r  <= 1'b0;
            m_data_r  <= {DWIDTH{1'b0}};
            m_user_r  <= {UWIDTH{1'b0}};
        end else if (load_s) begin
            m_valid_r <= 1'b1;
            m_last_r  <= last_nxt_s;
            m_data_r  <= s_axi_data;
            m_user_r  <= s_axi_user;
        end else if (m_valid_r && m_axi_ready) begin
            m_valid_r <= 1'b0;
            m_last_r  <= 1'b0;
        end else begin
            m_valid_r <= m_valid_r;
            m_last_r  <= m_last_r;
        end
    end

endmodule

// File: tb/tb_axi_sync_framer.sv
// Self-checking bench for axi_sync_framer: directed scenarios plus random traffic
// scored against a beat-level reference model.
module tb_axi_sync_framer;

    localparam int DW = 64;
    localparam int UW = 8;
    localparam int SC = 2;
    localparam int LW = 10;

    logic          clk = 1'b0;
    logic          areset;
    logic [LW-1:0] frame_len;
    logic          s_axi_ready, s_axi_valid, s_axi_equal;
    logic [DW-1:0] s_axi_data;
    logic [UW-1:0] s_axi_user;
    logic          m_axi_ready, m_axi_valid, m_axi_last, locked;
    logic [DW-1:0] m_axi_data;
    logic [UW-1:0] m_axi_user;
    logic [LW-1:0] frame_count;
    logic [15:0]   drop_count;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [UW-1:0] u;
        logic          l;
    } beat_t;

    beat_t exp_q[$];
    beat_t got_q[$];
    int    run_m, left_m, frames_m, drops_m;
    int    n_pass = 0;
    int    n_total = 0;
    bit    bp_done, rnd_done;

    axi_sync_framer #(.DWIDTH(DW), .UWIDTH(UW), .SYNC_COUNT(SC), .LWIDTH(LW)) dut (
        .clk(clk), .areset(areset), .frame_len(frame_len),
        .s_axi_ready(s_axi_ready), .s_axi_valid(s_axi_valid), .s_axi_data(s_axi_data),
        .s_axi_user(s_axi_user), .s_axi_equal(s_axi_equal),
        .m_axi_ready(m_axi_ready), .m_axi_valid(m_axi_valid), .m_axi_data(m_axi_data),
        .m_axi_user(m_axi_user), .m_axi_last(m_axi_last), .locked(locked),
        .frame_count(frame_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    // Reference model: frames described as "remaining payload beats" and
    // "run of equal beats"; broken runs are charged to the drop counter.
    initial begin
        forever begin
            @(negedge clk);
            if (areset) begin
                exp_q.delete(); got_q.delete();
                run_m = 0; left_m = 0; frames_m = 0; drops_m = 0;
            end else begin
                if (m_axi_valid && m_axi_ready) got_q.push_back({m_axi_data, m_axi_user, m_axi_last});
                if (s_axi_valid && s_axi_ready) begin
                    if (left_m > 0) begin
                        exp_q.push_back({s_axi_data, s_axi_user, (left_m == 1)});
                        left_m--;
                        if (left_m == 0) frames_m++;
                    end else if (s_axi_equal) begin
                        run_m++;
                        if (run_m == SC) begin
                            run_m  = 0;
                            left_m = (frame_len == '0) ? 1 : int'(frame_len);
                        end
                    end else begin
                        drops_m = (drops_m + run_m + 1 > 65535) ? 65535 : drops_m + run_m + 1;
                        run_m   = 0;
                    end
                end
            end
        end
    end

    task automatic send_beat(input logic eq, input logic [DW-1:0] d, input logic [UW-1:0] u);
        bit acc = 1'b0;
        s_axi_valid = 1'b1; s_axi_equal = eq; s_axi_data = d; s_axi_user = u;
        for (int k = 0; k < 1000 && !acc; k++) begin
            @(negedge clk); acc = s_axi_ready;
            @(posedge clk); #1;
        end
        s_axi_valid = 1'b0;
        if (!acc) begin
            n_total++;
            $display("FAIL send_timeout: s_axi_ready stayed 0 for 1000 cycles, required 1");
        end
    endtask

    task automatic idle(input int n);
        s_axi_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        areset = 1'b1; s_axi_valid = 1'b0; m_axi_ready = 1'b1;
        @(negedge clk); @(posedge clk); #1;
        areset = 1'b0;
    endtask

    function automatic logic [DW-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic test_reset();
        areset = 1'b1; #2;
        n_total++;
        if ({m_axi_valid, m_axi_last, locked, frame_count, drop_count, m_axi_data, m_axi_user} !== '0)
            $display("FAIL reset_outputs: v=%b l=%b lk=%b fc=%0d dc=%0d d=%h u=%h, required all 0",
                     m_axi_valid, m_axi_last, locked, frame_count, drop_count, m_axi_data, m_axi_user);
        else n_pass++;
        n_total++;
        if (s_axi_ready !== 1'b1) $display("FAIL reset_ready: got %b required 1", s_axi_ready);
        else n_pass++;
        @(posedge clk); #1; areset = 1'b0;
        idle(3);
        n_total++;
        if ({m_axi_valid, locked, frame_count, drop_count} !== '0)
            $display("FAIL idle_after_reset: v=%b lk=%b fc=%0d dc=%0d, required 0", m_axi_valid, locked, frame_count, drop_count);
        else n_pass++;
    endtask

    task automatic test_sync_frame();
        logic [DW-1:0] d;
        bit ok;
        do_reset(); frame_len = LW'(4);
        send_beat(1'b1, rnd64(), 8'h11);
        n_total++;
        if (locked !== 1'b0) $display("FAIL sf_locked_e1: got %b required 0", locked); else n_pass++;
        send_beat(1'b1, rnd64(), 8'h12);
        n_total++;
        if (locked !== 1'b1 || m_axi_valid !== 1'b0) $display("FAIL sf_locked_e2: locked=%b valid=%b required 1,0", locked, m_axi_valid);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            d = rnd64();
            send_beat(1'(i == 2), d, UW'(i));
            n_total++;
            if ({m_axi_valid, m_axi_data, m_axi_last, locked} !== {1'b1, d, 1'(i == 3), 1'(i != 3)})
                $display("FAIL sf_beat%0d: v=%b d=%h last=%b lk=%b, required 1 %h %b %b",
                         i, m_axi_valid, m_axi_data, m_axi_last, locked, d, i == 3, i != 3);
            else n_pass++;
        end
        idle(3);
        n_total++;
        if (frame_count !== LW'(1) || drop_count !== 16'd0)
            $display("FAIL sf_counters: fc=%0d dc=%0d, required 1 0", frame_count, drop_count);
        else n_pass++;
        ok = (got_q.size() == 4) && (exp_q.size() == 4);
        for (int i = 0; i < got_q.size() && ok; i++) if (got_q[i] !== exp_q[i]) ok = 1'b0;
        n_total++;
        if (!ok) $display("FAIL sf_stream: got %0d beats, required 4 matching model", got_q.size()); else n_pass++;
    endtask

    task automatic test_broken_sync();
        logic [DW-1:0] d;
        do_reset(); frame_len = LW'(1);
        send_beat(1'b1, rnd64(), 8'h01);
        send_beat(1'b0, rnd64(), 8'h02);
        send_beat(1'b1, rnd64(), 8'h03);
        send_beat(1'b1, rnd64(), 8'h04);
        d = rnd64();
        send_beat(1'b0, d, 8'h05);
        n_total++;
        if ({m_axi_valid, m_axi_data, m_axi_last, locked} !== {1'b1, d, 1'b1, 1'b0})
            $display("FAIL bs_d0: v=%b d=%h last=%b lk=%b, required 1 %h 1 0", m_axi_valid, m_axi_data, m_axi_last, locked, d);
        else n_pass++;
        idle(2);
        n_total++;
        if (drop_count !== 16'd2 || drops_m != 2 || frame_count !== LW'(1))
            $display("FAIL bs_drops: dc=%0d fc=%0d, required 2 1 (model %0d)", drop_count, frame_count, drops_m);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int  stab_bad = 0, rdy_bad = 0, stalls = 0;
        bit  ok, prev_stall = 1'b0;
        beat_t prev_b = '0, cur_b;
        do_reset(); frame_len = LW'(8); bp_done = 1'b0;
        fork
            begin
                for (int k = 0; !bp_done; k++) begin
                    m_axi_ready = ((k % 5) < 3);
                    @(posedge clk); #1;
                end
                m_axi_ready = 1'b1;
            end
            begin
                send_beat(1'b1, rnd64(), 8'hA0);
                send_beat(1'b1, rnd64(), 8'hA1);
                for (int i = 0; i < 8; i++) send_beat(1'($urandom_range(0, 1)), rnd64(), UW'($urandom));
                for (int k = 0; k < 100 && !(got_q.size() == exp_q.size() && !m_axi_valid); k++) idle(1);
                bp_done = 1'b1;
            end
            begin
                while (!bp_done) begin
                    @(negedge clk);
                    cur_b = {m_axi_data, m_axi_user, m_axi_last};
                    if (prev_stall && (!m_axi_valid || cur_b !== prev_b)) stab_bad++;
                    if (m_axi_valid && !m_axi_ready) begin
                        stalls++;
                        if (s_axi_ready) rdy_bad++;
                    end
                    prev_stall = m_axi_valid && !m_axi_ready;
                    prev_b = cur_b;
                end
            end
        join
        n_total++;
        if (stab_bad != 0) $display("FAIL bp_stable: %0d unstable stalled cycles, required 0", stab_bad); else n_pass++;
        n_total++;
        if (rdy_bad != 0 || stalls == 0) $display("FAIL bp_ready: %0d ready-while-stalled, %0d stalls, required 0 and >0", rdy_bad, stalls);
        else n_pass++;
        ok = (got_q.size() == 8) && (exp_q.size() == 8);
        for (int i = 0; i < got_q.size() && ok; i++) if (got_q[i] !== exp_q[i]) ok = 1'b0;
        n_total++;
        if (!ok) $display("FAIL bp_stream: got %0d beats, required 8 in order", got_q.size()); else n_pass++;
    endtask

    task automatic test_frame_len_edges();
        bit ok;
        do_reset(); frame_len = LW'(0);
        send_beat(1'b1, rnd64(), 8'h00); send_beat(1'b1, rnd64(), 8'h00);
        send_beat(1'b0, rnd64(), 8'h01);
        n_total++;
        if ({m_axi_valid, m_axi_last, locked} !== 3'b110)
            $display("FAIL fl_zero: v=%b last=%b lk=%b, required 1 1 0", m_axi_valid, m_axi_last, locked);
        else n_pass++;
        frame_len = LW'(3);
        send_beat(1'b1, rnd64(), 8'h00); send_beat(1'b1, rnd64(), 8'h00);
        send_beat(1'b0, rnd64(), 8'h10);
        frame_len = LW'(6);
        send_beat(1'b1, rnd64(), 8'h11); send_beat(1'b0, rnd64(), 8'h12);
        n_total++;
        if ({m_axi_last, locked} !== 2'b10) $display("FAIL fl_mid_change: last=%b lk=%b, required 1 0", m_axi_last, locked);
        else n_pass++;
        send_beat(1'b1, rnd64(), 8'h00); send_beat(1'b1, rnd64(), 8'h00);
        for (int i = 0; i < 5; i++) send_beat(1'b1, rnd64(), UW'(8'h20 + i));
        n_total++;
        if ({m_axi_last, locked} !== 2'b01) $display("FAIL fl_six_b5: last=%b lk=%b, required 0 1", m_axi_last, locked);
        else n_pass++;
        send_beat(1'b0, rnd64(), 8'h25);
        idle(3);
        ok = (got_q.size() == 10) && (exp_q.size() == 10);
        for (int i = 0; i < got_q.size() && ok; i++) if (got_q[i] !== exp_q[i]) ok = 1'b0;
        n_total++;
        if (!ok || frame_count !== LW'(3)) $display("FAIL fl_stream: %0d beats fc=%0d, required 10 3", got_q.size(), frame_count);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset(); frame_len = LW'(1);
        for (int f = 0; f < 1100; f++) begin
            send_beat(1'b1, rnd64(), 8'hE0); send_beat(1'b1, rnd64(), 8'hE1);
            send_beat(1'b0, rnd64(), UW'(f));
        end
        idle(3);
        n_total++;
        if (frame_count !== LW'(76) || frame_count !== LW'(frames_m) || drop_count !== 16'd0)
            $display("FAIL b2b_wrap: fc=%0d dc=%0d, required %0d 0", frame_count, drop_count, 1100 % (1 << LW));
        else n_pass++;
        n_total++;
        if (got_q.size() != 1100 || got_q != exp_q) $display("FAIL b2b_stream: got %0d beats, required 1100", got_q.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        do_reset(); frame_len = LW'(5);
        send_beat(1'b1, rnd64(), 8'h00); send_beat(1'b1, rnd64(), 8'h00);
        m_axi_ready = 1'b0;
        send_beat(1'b0, rnd64(), 8'h55);
        n_total++;
        if ({m_axi_valid, locked} !== 2'b11) $display("FAIL rm_pre: v=%b lk=%b, required 1 1", m_axi_valid, locked);
        else n_pass++;
        #3 areset = 1'b1;
        #1;
        n_total++;
        if ({m_axi_valid, m_axi_last, locked, frame_count, drop_count, m_axi_data, m_axi_user} !== '0)
            $display("FAIL rm_async: v=%b lk=%b d=%h, required all 0", m_axi_valid, locked, m_axi_data);
        else n_pass++;
        @(posedge clk); #1; areset = 1'b0; m_axi_ready = 1'b1;
        send_beat(1'b1, rnd64(), 8'h00); send_beat(1'b0, rnd64(), 8'h66);
        idle(3);
        n_total++;
        if (got_q.size() != 0 || drop_count !== 16'd2 || locked !== 1'b0)
            $display("FAIL rm_resync: out=%0d dc=%0d lk=%b, required 0 2 0", got_q.size(), drop_count, locked);
        else n_pass++;
        frame_len = LW'(1);
        send_beat(1'b1, rnd64(), 8'h00); send_beat(1'b1, rnd64(), 8'h00);
        send_beat(1'b0, rnd64(), 8'h77);
        idle(3);
        n_total++;
        if (frame_count !== LW'(1) || got_q.size() != 1 || got_q != exp_q)
            $display("FAIL rm_frame: fc=%0d out=%0d, required 1 1", frame_count, got_q.size());
        else n_pass++;
    endtask

    task automatic test_random();
        do_reset(); frame_len = LW'(3); rnd_done = 1'b0;
        fork
            begin
                while (!rnd_done) begin
                    m_axi_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk); #1;
                end
                m_axi_ready = 1'b1;
            end
            begin
                for (int i = 0; i < 600; i++) begin
                    if ($urandom_range(0, 4) == 0) idle(1);
                    else begin
                        if ($urandom_range(0, 9) == 0) frame_len = LW'($urandom_range(0, 5));
                        send_beat(1'($urandom_range(0, 2) != 0), rnd64(), UW'($urandom));
                    end
                end
                for (int k = 0; k < 200 && !(got_q.size() == exp_q.size() && !m_axi_valid); k++) idle(1);
                rnd_done = 1'b1;
            end
        join
        n_total++;
        if (got_q.size() == 0 || got_q != exp_q) $display("FAIL rnd_stream: got %0d beats, required %0d matching", got_q.size(), exp_q.size());
        else n_pass++;
        n_total++;
        if (frame_count !== LW'(frames_m) || drop_count !== 16'(drops_m) || locked !== (left_m > 0))
            $display("FAIL rnd_status: fc=%0d dc=%0d lk=%b, required %0d %0d %b", frame_count, drop_count, locked, frames_m % (1 << LW), drops_m, left_m > 0);
        else n_pass++;
    endtask

    initial begin
        areset = 1'b1; frame_len = '0; s_axi_valid = 1'b0; s_axi_equal = 1'b0;
        s_axi_data = '0; s_axi_user = '0; m_axi_ready = 1'b1;
        test_reset();
        test_sync_frame();
        test_broken_sync();
        test_backpressure();
        test_frame_len_edges();
        test_reset_mid_frame();
        test_random();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
